// File: rtl/mio_bus_dma.sv
// -----------------------------------------------------------------------------
// mio_bus_dma
//   Bus initiator for the MIO bus. It copies `length` 32-bit words from
//   src_addr to dst_addr with no CPU involvement. Each word is one read cycle
//   followed by one write cycle. The copy is strictly ascending and word by
//   word. A stalled responder (MIO_ready low) is tolerated for up to TIMEOUT
//   consecutive cycles. After that the transfer is aborted and error is set.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   start       launch a transfer (sampled only while idle)
//   src_addr    source byte address, low two bits ignored
//   dst_addr    destination byte address, low two bits ignored
//   length      number of words to copy
//   busy        transfer in progress, DMA owns the bus
//   done        one-cycle pulse when a transfer ends (normally or aborted)
//   error       sticky abort flag, cleared by the next accepted start
//   words_done  words fully written in the current/last transfer
//   bus_req     a bus cycle is presented this clock
//   Addr_out    word-aligned bus address
//   Data_out    bus write data
//   mem_w       1 = write cycle, 0 = read cycle
//   Data_in     bus read data
//   MIO_ready   responder completes the current cycle on this edge
// -----------------------------------------------------------------------------
module mio_bus_dma #(
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic             bus_req,
    output logic [31:0]      Addr_out,
    output logic [31:0]      Data_out,
    output logic             mem_w,
    input  logic [31:0]      Data_in,
    input  logic             MIO_ready
);

    typedef enum logic [2:0] {IDLE, RD, WR, FIN, ABT} state_t;

    state_t           state, next_state;
    logic [31:0]      cur_src, cur_dst, data_reg;
    logic [LEN_W-1:0] len_reg;
    logic [15:0]      wait_cnt;
    logic             timeout;
    logic             last_word;

    // wait_cnt holds the stall cycles already seen. This cycle is the
    // TIMEOUT-th stall when the counter sits at TIMEOUT-1 and ready is low.
    assign timeout   = ((state == RD) || (state == WR)) && !MIO_ready &&
                       (wait_cnt == 16'(TIMEOUT - 1));
    assign last_word = ((words_done + LEN_W'(1)) == len_reg);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (length == '0) ? FIN : RD;
            RD: begin
                if (timeout)        next_state = ABT;
                else if (MIO_ready) next_state = WR;
            end
            WR: begin
                if (timeout)        next_state = ABT;
                else if (MIO_ready) next_state = last_word ? FIN : RD;
            end
            FIN:     next_state = IDLE;
            ABT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded only from registered state and datapath registers.
    // They therefore hold steady for the whole duration of a stalled cycle.
    always_comb begin
        busy     = 1'b0;
        bus_req  = 1'b0;
        mem_w    = 1'b0;
        done     = 1'b0;
        Addr_out = '0;
        Data_out = '0;
        case (state)
            RD: begin
                busy     = 1'b1;
                bus_req  = 1'b1;
                Addr_out = cur_src;
            end
            WR: begin
                busy     = 1'b1;
                bus_req  = 1'b1;
                mem_w    = 1'b1;
                Addr_out = cur_dst;
                Data_out = data_reg;
            end
            FIN, ABT: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: addresses, captured word, progress and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_src    <= '0;
            cur_dst    <= '0;
            data_reg   <= '0;
            len_reg    <= '0;
            words_done <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_src    <= src_addr & ~32'h3;
                        cur_dst    <= dst_addr & ~32'h3;
                        len_reg    <= length;
                        words_done <= '0;
                        error      <= 1'b0;
                    end
                end
                RD: begin
                    // timeout implies MIO_ready is low, so an aborting cycle
                    // never captures data.
                    if (timeout)        error    <= 1'b1;
                    else if (MIO_ready) data_reg <= Data_in;
                end
                WR: begin
                    if (timeout) begin
                        error <= 1'b1;
                    end else if (MIO_ready) begin
                        words_done <= words_done + LEN_W'(1);
                        cur_src    <= cur_src + 32'd4;
                        cur_dst    <= cur_dst + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall counter: restarts on every state change and on every completed cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if ((next_state != state) || MIO_ready) begin
            wait_cnt <= '0;
        end else if ((state == RD) || (state == WR)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mio_bus_dma.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_dma
//   Drives copy transfers into a 256-word memory model. That model acts as the
//   bus responder. The bench predicts each transfer from the copy rules: the
//   ascending word copy, the 2-cycles-per-word timing, stall cycles, and the
//   abort after TIMEOUT stalls.
// -----------------------------------------------------------------------------
module tb_mio_bus_dma;

    localparam int LEN_W   = 10;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] length = '0;
    logic             busy, done, error, bus_req, mem_w;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      Addr_out, Data_out, Data_in;
    logic             MIO_ready = 1'b1;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    mio_bus_dma #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .bus_req    (bus_req),
        .Addr_out   (Addr_out),
        .Data_out   (Data_out),
        .mem_w      (mem_w),
        .Data_in    (Data_in),
        .MIO_ready  (MIO_ready)
    );

    assign Data_in = mem[Addr_out[9:2]];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] widx(input logic [31:0] base, input int i);
        logic [31:0] a;
        a = base + 32'(4 * i);
        return a[9:2];
    endfunction

    // Transfer modes:
    //   0 = ready tied high
    //   1 = random stalls, at most 3 in a row
    //   2 = ready drops at the first write and stays low (forces abort)
    task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int len, input int mode, input bit poke);
        logic [31:0] exp_mem [0:255];
        logic [31:0] exp_data [$];
        logic [31:0] sa, da, p_addr, p_data, w;
        logic        p_w, r;
        int          zeros, zrun, done_cyc, nrd, nwr, bad, exp_cyc;
        bit          seen_wr, got_done, prev_stall;

        sa = s & ~32'h3;
        da = d & ~32'h3;
        exp_mem = mem;
        if (mode != 2) begin
            for (int i = 0; i < len; i++) begin
                w = exp_mem[widx(sa, i)];
                exp_data.push_back(w);
                exp_mem[widx(da, i)] = w;
            end
        end
        zeros = 0; zrun = 0; done_cyc = 0; nrd = 0; nwr = 0;
        seen_wr = 0; got_done = 0; prev_stall = 0;
        p_addr = '0; p_data = '0; p_w = 1'b0;

        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = LEN_W'(len);
        MIO_ready = 1'b1;
        for (int cyc = 1; cyc <= 4000 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) check({tag, " error cleared"}, error, 1'b0);
            check({tag, " bus_req==busy"}, bus_req, busy);
            if (prev_stall && bus_req) begin
                check({tag, " stall addr"}, Addr_out, p_addr);
                check({tag, " stall mem_w"}, mem_w, p_w);
                check({tag, " stall data"}, Data_out, p_data);
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (zrun >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                default: r = !(seen_wr || (bus_req && mem_w));
            endcase
            if (bus_req && mem_w) seen_wr = 1;
            MIO_ready = r;
            if (busy && !r) begin zeros++; zrun++; end else zrun = 0;
            prev_stall = bus_req && !r;
            p_addr = Addr_out; p_data = Data_out; p_w = mem_w;
            if (bus_req && r) begin
                if (!mem_w) begin
                    check({tag, " read addr"}, Addr_out, sa + 32'(4 * nrd));
                    nrd++;
                end else begin
                    check({tag, " write addr"}, Addr_out, da + 32'(4 * nwr));
                    if (nwr < exp_data.size())
                        check({tag, " write data"}, Data_out, exp_data[nwr]);
                    else
                        check({tag, " unexpected write"}, 32'(nwr), 32'(exp_data.size()));
                    mem[Addr_out[9:2]] = Data_out;
                    nwr++;
                end
            end
            if (poke && (busy || done)) begin
                start = 1'b1; src_addr = 32'h40; dst_addr = 32'h44; length = LEN_W'(3);
            end
        end
        if (!got_done) check({tag, " done timeout"}, 32'(got_done), 32'd1);

        exp_cyc = (mode == 2) ? 2 + TIMEOUT : 1 + 2 * len + zeros;
        check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_cyc));
        check({tag, " busy at done"}, busy, 1'b0);
        check({tag, " words_done"}, 32'(words_done), (mode == 2) ? 32'd0 : 32'(len));
        check({tag, " error"}, error, (mode == 2) ? 1'b1 : 1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({tag, " memory"}, 32'(bad), 32'd0);

        @(posedge clk);
        #1 start = 1'b0;
        MIO_ready = 1'b1;
        @(negedge clk);
        check({tag, " done one cycle"}, done, 1'b0);
        check({tag, " idle after"}, busy, 1'b0);
        check({tag, " error sticky"}, error, (mode == 2) ? 1'b1 : 1'b0);
    endtask

    initial begin
        logic [31:0] snap [0:255];
        int          bad;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset bus_req", bus_req, 1'b0);
        check("reset Addr_out", Addr_out, 32'h0);
        check("reset Data_out", Data_out, 32'h0);
        check("reset words_done", 32'(words_done), 32'h0);
        check("reset error", error, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        run_xfer("basic", 32'h100, 32'h200, 4, 0, 0);
        run_xfer("len0", 32'h100, 32'h200, 0, 0, 0);
        run_xfer("stall", 32'h010, 32'h300, 2, 1, 0);
        run_xfer("abort", 32'h020, 32'h320, 3, 2, 0);
        run_xfer("recover", 32'h021, 32'h322, 3, 0, 0);
        run_xfer("wrap", 32'hFFFF_FFFC, 32'h300, 2, 0, 1);
        for (int t = 0; t < 6; t++)
            run_xfer($sformatf("rand%0d", t), 32'($urandom_range(0, 255)) << 2,
                     32'($urandom_range(0, 255)) << 2, $urandom_range(1, 20), 1,
                     1'($urandom_range(0, 1)));

        // Reset in the middle of a transfer, while word 2 is being read
        snap = mem;
        @(negedge clk);
        start = 1'b1; src_addr = 32'h000; dst_addr = 32'h380; length = LEN_W'(5);
        MIO_ready = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus_req && mem_w) mem[Addr_out[9:2]] = Data_out;
        end
        check("rst mid word2 addr", Addr_out, 32'h008);
        #2 rst = 1'b0;
        #1;
        check("rst mid busy", busy, 1'b0);
        check("rst mid bus_req", bus_req, 1'b0);
        check("rst mid mem_w", mem_w, 1'b0);
        check("rst mid Addr_out", Addr_out, 32'h0);
        check("rst mid Data_out", Data_out, 32'h0);
        check("rst mid words_done", 32'(words_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("post rst idle", bus_req, 1'b0);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 2 && mem[8'hE0 + i] !== snap[i]) bad++;
            if (i >= 2 && mem[8'hE0 + i] !== snap[8'hE0 + i]) bad++;
        end
        check("rst mid dst words", 32'(bad), 32'd0);

        run_xfer("after rst", 32'h040, 32'h140, 3, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
